// File: rtl/branch_resolve_if.sv
// EX-stage branch bundle between the pipeline and branch_resolve: fetch lookup,
// resolve inputs, redirect/flush outputs and statistics.
interface branch_resolve_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        cmp_s;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_stall, ex_pc, ex_target,
           ex_pred_taken, cmp_s,
    input  pred_taken, redirect, redirect_pc, flush, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_stall, ex_pc, ex_target,
           ex_pred_taken, cmp_s,
    output pred_taken, redirect, redirect_pc, flush, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// Resolves EX branches against the fetch prediction, trains a 2-bit BHT, counts stats.
// Latency: redirect/flush one cycle after resolve, pred_taken combinational; stalls hold resolution.
module branch_resolve #(
  parameter int BHT_IDX_W = 4
) (
  input logic       clk,
  input logic       reset,
  branch_resolve_if.slave br
);

  localparam int NENT = 1 << BHT_IDX_W;

  typedef enum logic {IDLE, REDIR} state_t;

  state_t                   state;
  logic [NENT-1:0][1:0]     bht;
  logic                     redirect_q;
  logic [31:0]              redirect_pc_q;
  logic [15:0]              branch_cnt_q;
  logic [15:0]              mispredict_cnt_q;

  logic                     res;
  logic                     act;
  logic                     mp;
  logic [31:0]              fall_pc;
  logic [BHT_IDX_W-1:0]     ridx;
  logic [BHT_IDX_W-1:0]     widx;

  assign ridx    = br.if_pc[BHT_IDX_W+1:2];
  assign widx    = br.ex_pc[BHT_IDX_W+1:2];
  // The instruction in EX during REDIR is wrong-path, so it never resolves.
  assign res     = br.ex_valid & br.ex_is_branch & ~br.ex_stall & (state == IDLE);
  assign act     = br.cmp_s;
  assign mp      = act ^ br.ex_pred_taken;
  assign fall_pc = br.ex_pc + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= 32'h0;
      bht              <= {NENT{2'b01}};
      branch_cnt_q     <= 16'h0;
      mispredict_cnt_q <= 16'h0;
    end else begin
      state      <= IDLE;
      redirect_q <= 1'b0;
      if (res) begin
        branch_cnt_q <= branch_cnt_q + 16'd1;
        if (act) begin
          if (bht[widx] != 2'b11) bht[widx] <= bht[widx] + 2'd1;
        end else begin
          if (bht[widx] != 2'b00) bht[widx] <= bht[widx] - 2'd1;
        end
        if (mp) begin
          state            <= REDIR;
          redirect_q       <= 1'b1;
          redirect_pc_q    <= act ? br.ex_target : fall_pc;
          mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
        end
      end
    end
  end

  assign br.pred_taken     = bht[ridx][1];
  assign br.redirect       = redirect_q;
  assign br.flush          = redirect_q;
  assign br.redirect_pc    = redirect_pc_q;
  assign br.branch_cnt     = branch_cnt_q;
  assign br.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a behavioural outcome model checked every cycle.
module tb_branch_resolve;

  logic clk = 1'b0;
  logic reset = 1'b0;
  branch_resolve_if bif ();

  branch_resolve #(.BHT_IDX_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .br    (bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: counter values, 0..3 history per entry, and whether this cycle is a redirect.
  int          m_bht[16] = '{default: 1};
  int          m_bcnt = 0;
  int          m_mcnt = 0;
  bit          m_redirect = 0;
  logic [31:0] m_rpc = 32'h0;
  bit          m_shadow;
  int          m_idx;
  bit          started = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_bcnt = 0; m_mcnt = 0; m_redirect = 0; m_rpc = 32'h0;
    end else begin
      m_shadow   = m_redirect;
      m_redirect = 0;
      if (!m_shadow && bif.ex_valid && bif.ex_is_branch && !bif.ex_stall) begin
        m_idx = int'(bif.ex_pc >> 2) % 16;
        if (bif.cmp_s) m_bht[m_idx] = (m_bht[m_idx] == 3) ? 3 : m_bht[m_idx] + 1;
        else           m_bht[m_idx] = (m_bht[m_idx] == 0) ? 0 : m_bht[m_idx] - 1;
        m_bcnt = (m_bcnt + 1) % 65536;
        if (bif.cmp_s != bif.ex_pred_taken) begin
          m_mcnt     = (m_mcnt + 1) % 65536;
          m_redirect = 1;
          m_rpc      = bif.cmp_s ? bif.ex_target : bif.ex_pc + 32'd4;
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_pred", bif.pred_taken, (m_bht[int'(bif.if_pc >> 2) % 16] >= 2) ? 1 : 0);
      chk("m_redirect", bif.redirect, m_redirect);
      chk("m_flush", bif.flush, m_redirect);
      chk("m_redirect_pc", bif.redirect_pc, m_rpc);
      chk("m_branch_cnt", bif.branch_cnt, m_bcnt[15:0]);
      chk("m_mispredict_cnt", bif.mispredict_cnt, m_mcnt[15:0]);
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pt, input logic c, input int stalls);
    logic [15:0] cnt0;
    cnt0 = bif.branch_cnt;
    bif.ex_valid = 1; bif.ex_is_branch = 1; bif.ex_pc = pc; bif.ex_target = tgt;
    bif.ex_pred_taken = pt; bif.cmp_s = c; bif.ex_stall = (stalls > 0);
    for (int i = 0; i < stalls; i++) begin
      @(posedge clk); #1;
      chk("stall_no_redirect", bif.redirect, 0);
      chk("stall_no_count", bif.branch_cnt, cnt0);
    end
    bif.ex_stall = 0;
    @(posedge clk); #1;
    bif.ex_valid = 0;
  endtask

  initial begin
    int n;
    bif.if_pc = 0; bif.ex_valid = 0; bif.ex_is_branch = 0; bif.ex_stall = 0;
    bif.ex_pc = 0; bif.ex_target = 0; bif.ex_pred_taken = 0; bif.cmp_s = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;

    // Reset state
    for (int i = 0; i < 16; i++) begin
      bif.if_pc = 32'(i * 4); #1;
      chk("rst_pred", bif.pred_taken, 0);
    end
    chk("rst_redirect", bif.redirect, 0);
    chk("rst_flush", bif.flush, 0);
    chk("rst_bcnt", bif.branch_cnt, 0);
    chk("rst_mcnt", bif.mispredict_cnt, 0);

    // Non-branch and invalid slots do nothing
    @(posedge clk); #1;
    bif.ex_valid = 1; bif.ex_is_branch = 0; bif.ex_pc = 32'h100; bif.cmp_s = 1;
    @(posedge clk); #1;
    bif.ex_valid = 0; bif.ex_is_branch = 1;
    @(posedge clk); #1;
    bif.ex_is_branch = 0;
    chk("nonbr_bcnt", bif.branch_cnt, 0);

    // Correctly predicted not-taken
    issue(32'h100, 32'h300, 0, 0, 0);
    chk("nt_redirect", bif.redirect, 0);
    chk("nt_bcnt", bif.branch_cnt, 1);
    chk("nt_mcnt", bif.mispredict_cnt, 0);
    bif.if_pc = 32'h100; #1;
    chk("nt_pred", bif.pred_taken, 0);

    // Mispredict taken, then a wrong-path mispredict in the shadow cycle
    issue(32'h104, 32'h200, 0, 1, 0);
    chk("mp_redirect", bif.redirect, 1);
    chk("mp_flush", bif.flush, 1);
    chk("mp_rpc", bif.redirect_pc, 32'h200);
    chk("mp_mcnt", bif.mispredict_cnt, 1);
    bif.if_pc = 32'h104; #1;
    chk("mp_pred", bif.pred_taken, 1);
    bif.ex_valid = 1; bif.ex_is_branch = 1; bif.ex_pc = 32'h108; bif.ex_target = 32'h400;
    bif.ex_pred_taken = 0; bif.cmp_s = 1;
    @(posedge clk); #1;
    bif.ex_valid = 0;
    chk("shadow_redirect", bif.redirect, 0);
    chk("shadow_bcnt", bif.branch_cnt, 2);
    chk("shadow_mcnt", bif.mispredict_cnt, 1);
    bif.if_pc = 32'h108; #1;
    chk("shadow_pred", bif.pred_taken, 0);

    // Stalled branch, mispredicted fall-through wrapping to 0
    issue(32'hFFFF_FFFC, 32'h500, 1, 0, 3);
    chk("stall_redirect", bif.redirect, 1);
    chk("stall_rpc", bif.redirect_pc, 32'h0);
    chk("stall_bcnt", bif.branch_cnt, 3);
    chk("stall_mcnt", bif.mispredict_cnt, 2);
    @(posedge clk); #1;
    chk("stall_one_pulse", bif.redirect, 0);

    // BHT saturation at entry 5
    for (int i = 0; i < 5; i++) issue(32'h14, 32'h80, 1, 1, 0);
    bif.if_pc = 32'h14; #1;
    chk("sat_pred", bif.pred_taken, 1);
    issue(32'h14, 32'h80, 1, 0, 0);
    chk("sat_dec1_pred", bif.pred_taken, 1);
    @(posedge clk); #1;
    issue(32'h14, 32'h80, 1, 0, 0);
    chk("sat_dec2_pred", bif.pred_taken, 0);
    @(posedge clk); #1;

    // branch_cnt wrap
    n = 65535 - m_bcnt;
    bif.ex_valid = 1; bif.ex_is_branch = 1; bif.ex_pc = 32'h40;
    bif.ex_pred_taken = 0; bif.cmp_s = 0;
    repeat (n) @(posedge clk);
    #1 bif.ex_valid = 0;
    chk("wrap_ffff", bif.branch_cnt, 16'hFFFF);
    issue(32'h40, 32'h0, 0, 0, 0);
    chk("wrap_zero", bif.branch_cnt, 16'h0);

    // Reset during REDIRECT
    issue(32'h104, 32'h200, 0, 1, 0);
    chk("rr_redirect_before", bif.redirect, 1);
    #2 reset = 0;
    #1;
    chk("rr_redirect", bif.redirect, 0);
    chk("rr_flush", bif.flush, 0);
    chk("rr_rpc", bif.redirect_pc, 0);
    chk("rr_mcnt", bif.mispredict_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    chk("rr_after_redirect", bif.redirect, 0);
    bif.if_pc = 32'h104; #1;
    chk("rr_after_pred", bif.pred_taken, 0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
